mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one memory port between instruction fetch (requester 0) and data load/store (requester 1) in the multi-cycle memory variant of the RISC-V core. Round-robin arbitration, holds grant for a full transaction, and drives the select of the 2-way address/data multiplexer in front of the memory. A per-transaction watchdog aborts transactions the memory never acknowledges.

Parameters:
ADDR_WIDTH, 32, width of request and memory addresses
DATA_WIDTH, 32, width of write/read data
TIMEOUT, 16, max cycles in BUSY without mem_ack before abort (>=2)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
req0 / req1  input  1  request from requester 0 / 1; held high until its done
addr0 / addr1  input  ADDR_WIDTH  request address
wdata0 / wdata1  input  DATA_WIDTH  write data
we0 / we1  input  1  1 = write, 0 = read
mem_ack  input  1  memory completion, one-cycle pulse
mem_rdata  input  DATA_WIDTH  read data, valid with mem_ack
mem_req  output  1  memory transaction active
mem_addr  output  ADDR_WIDTH  latched address of granted requester
mem_wdata  output  DATA_WIDTH  latched write data
mem_we  output  1  latched write enable
sel  output  1  mux select: 0 = requester 0, 1 = requester 1
gnt0 / gnt1  output  1  requester owns the port (high through BUSY)
done0 / done1  output  1  one-cycle completion pulse to owner
err  output  1  valid with done; 1 = watchdog abort
rdata  output  DATA_WIDTH  registered read data, valid with done

Behaviour:
- All outputs registered. Reset (sync, high): state=IDLE; mem_req, mem_we, sel, gnt0/1, done0/1, err = 0; mem_addr, mem_wdata, rdata = 0; counter=0; last=1 (so requester 0 wins first tie).
- States: IDLE, BUSY.
- IDLE, no req: remain; done/err low.
- IDLE, exactly one req: grant it. Both reqs: grant requester != last. On that edge: sel=winner, gntX=1, latch addr/wdata/we into mem_*, mem_req=1, counter=0, ->BUSY. Latency: req sampled at edge N, mem_req high after edge N.
- BUSY: mem_* and sel held constant; requester inputs ignored (req drop mid-transaction does not cancel).
- BUSY, mem_ack=1: rdata=mem_rdata (writes also capture it; content don't-care), doneX=1, err=0, gnt/mem_req/mem_we -> 0, last=sel, ->IDLE.
- BUSY, no ack, counter==TIMEOUT-1: abort; doneX=1, err=1, rdata=0, gnt/mem_req -> 0, last=sel, ->IDLE. Otherwise counter+1.
- mem_ack and timeout same cycle: ack wins (err=0).
- done/err are single-cycle; cleared the following cycle.
- IDLE is a mandatory turnaround cycle: new grant evaluated no earlier than the cycle after done. Requester must drop req on seeing done or it is re-arbitrated.
- mem_ack while IDLE ignored, no state change.
- Reset in BUSY: next cycle all outputs at reset values; no done issued for aborted transaction.
- Counter width clog2(TIMEOUT); no wrap since it exits at TIMEOUT-1.
- sel changes only on IDLE->BUSY edge.

Test Plan:
- Single read: req0=1, addr0=0x100, we0=0; mem_ack 3 cycles after mem_req with 0xDEADBEEF -> mem_req high 3 cycles, mem_addr=0x100, sel=0, done0 pulse with rdata=0xDEADBEEF, err=0.
- Tie after reset: req0 and req1 held, mem_ack 1 cycle after mem_req each -> grants alternate 0,1,0,1 with one IDLE cycle between, sel tracks grant.
- Write: req1=1, addr1=0x2000, wdata1=0x12345678, we1=1 -> mem_we=1, mem_wdata=0x12345678, sel=1, done1 on ack.
- Timeout, TIMEOUT=16: req0, never ack -> mem_req high exactly 16 cycles, done0=1, err=1, rdata=0; next tie grants requester 1.
- Ack on final timeout cycle -> done with err=0, rdata = mem_rdata.
- Reset in BUSY after 2 cycles: reset 1 cycle -> all outputs 0, no done; req1 afterwards granted first cycle post-reset.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester and memory-side signals around the shared memory port.
// The arbiter takes the slave view; the requesters plus memory take the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req0;
  logic                  req1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  we0;
  logic                  we1;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic                  sel;
  logic                  gnt0;
  logic                  gnt1;
  logic                  done0;
  logic                  done1;
  logic                  err;
  logic [DATA_WIDTH-1:0] rdata;

  modport slave (
    input  req0, req1, addr0, addr1, wdata0, wdata1, we0, we1, mem_ack, mem_rdata,
    output mem_req, mem_addr, mem_wdata, mem_we, sel, gnt0, gnt1, done0, done1, err, rdata
  );

  modport master (
    output req0, req1, addr0, addr1, wdata0, wdata1, we0, we1, mem_ack, mem_rdata,
    input  mem_req, mem_addr, mem_wdata, mem_we, sel, gnt0, gnt1, done0, done1, err, rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the single memory port shared by instruction fetch (0) and
// load/store (1); holds the grant for a whole transaction and aborts on watchdog expiry.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  last_q, last_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d;
  logic                  sel_q, sel_d;
  logic                  gnt0_q, gnt0_d;
  logic                  gnt1_q, gnt1_d;
  logic                  done0_q, done0_d;
  logic                  done1_q, done1_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  winner;

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    sel_d       = sel_q;
    gnt0_d      = gnt0_q;
    gnt1_d      = gnt1_q;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    winner      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // On a tie the requester that did not own the previous transaction wins.
          winner      = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
          state_d     = BUSY;
          sel_d       = winner;
          gnt0_d      = ~winner;
          gnt1_d      = winner;
          mem_req_d   = 1'b1;
          mem_addr_d  = winner ? bus.addr1  : bus.addr0;
          mem_wdata_d = winner ? bus.wdata1 : bus.wdata0;
          mem_we_d    = winner ? bus.we1    : bus.we0;
          cnt_d       = '0;
        end
      end

      BUSY: begin
        // An ack arriving on the last watchdog cycle still completes normally.
        if (bus.mem_ack || (cnt_q == CNT_LAST)) begin
          state_d   = IDLE;
          done0_d   = ~sel_q;
          done1_d   = sel_q;
          err_d     = ~bus.mem_ack;
          rdata_d   = bus.mem_ack ? bus.mem_rdata : '0;
          gnt0_d    = 1'b0;
          gnt1_d    = 1'b0;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          last_d    = sel_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      sel_q       <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      sel_q       <= sel_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.sel       = sel_q;
  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model predicts owner,
// latched request and completion cycle; a negedge monitor checks what the DUT presents.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  typedef struct {
    int            owner;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          we;
    logic          err;
    logic [DW-1:0] rdata;
    int            end_cyc;
  } txn_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   checks   = 0;
  int   failures = 0;

  txn_t          sb[$];
  int            force_lat[$];
  logic [DW-1:0] force_data[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"},   bus.mem_req,   0);
    check({tag, "_mem_we"},    bus.mem_we,    0);
    check({tag, "_sel"},       bus.sel,       0);
    check({tag, "_gnt0"},      bus.gnt0,      0);
    check({tag, "_gnt1"},      bus.gnt1,      0);
    check({tag, "_done0"},     bus.done0,     0);
    check({tag, "_done1"},     bus.done1,     0);
    check({tag, "_err"},       bus.err,       0);
    check({tag, "_mem_addr"},  bus.mem_addr,  0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    check({tag, "_rdata"},     bus.rdata,     0);
  endtask

  task automatic set_inputs(input int id, input logic rq, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic w);
    if (id == 0) begin
      bus.req0 = rq; bus.addr0 = a; bus.wdata0 = d; bus.we0 = w;
    end else begin
      bus.req1 = rq; bus.addr1 = a; bus.wdata1 = d; bus.we1 = w;
    end
  endtask

  // Noisy mode scrambles request fields every cycle and may drop req once granted.
  task automatic wait_done(input int id, input bit noisy);
    int   n = 0;
    logic dn, g, rq;
    forever begin
      @(negedge clk);
      n++;
      dn = (id == 0) ? bus.done0 : bus.done1;
      g  = (id == 0) ? bus.gnt0  : bus.gnt1;
      if (dn || n >= 300) break;
      if (noisy) begin
        rq = (id == 0) ? bus.req0 : bus.req1;
        if (g && $urandom_range(0, 3) == 0) rq = 1'b0;
        set_inputs(id, rq, $urandom, $urandom, 1'($urandom_range(0, 1)));
      end
    end
    check($sformatf("done_wait_req%0d", id), dn, 1);
    if (id == 0) bus.req0 = 1'b0;
    else         bus.req1 = 1'b0;
  endtask

  task automatic issue(input int id, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic w, input bit noisy);
    @(negedge clk);
    set_inputs(id, 1'b1, a, d, w);
    wait_done(id, noisy);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  // Reference model and memory responder: decides when a grant must appear, who
  // gets it, and the ack latency; pushes the expected completion to the scoreboard.
  initial begin : responder
    int            free_at = 0;
    int            ack_at = -1;
    int            last_owner = 1;
    int            lat, owner, dur;
    logic          prev_req = 1'b0;
    logic          desync = 1'b0;
    logic          started;
    logic [DW-1:0] ack_data = '0;
    txn_t          t;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        sb.delete();
        free_at    = cyc + 1;
        ack_at     = -1;
        last_owner = 1;
        desync     = 1'b0;
      end else begin
        started = bus.mem_req && !prev_req;
        if (!desync && cyc >= free_at && (bus.req0 || bus.req1)) begin
          owner = (bus.req0 && bus.req1) ? 1 - last_owner : (bus.req1 ? 1 : 0);
          check("grant_start", started, 1);
          if (!started) begin
            desync = 1'b1;
          end else begin
            t.owner = owner;
            t.addr  = (owner == 1) ? bus.addr1  : bus.addr0;
            t.wdata = (owner == 1) ? bus.wdata1 : bus.wdata0;
            t.we    = (owner == 1) ? bus.we1    : bus.we0;
            check("start_owner", {bus.sel, bus.gnt1, bus.gnt0},
                  {owner == 1, owner == 1, owner == 0});
            check("start_addr",  bus.mem_addr,  t.addr);
            check("start_wdata", bus.mem_wdata, t.wdata);
            check("start_we",    bus.mem_we,    t.we);
            if (force_lat.size() > 0) begin
              lat = force_lat.pop_front();
            end else begin
              case ($urandom_range(0, 9))
                0:       lat = 0;
                1:       lat = TIMEOUT + 1;
                2:       lat = TIMEOUT;
                default: lat = $urandom_range(1, 5);
              endcase
            end
            ack_data  = (force_data.size() > 0) ? force_data.pop_front() : DW'($urandom);
            t.err     = !(lat >= 1 && lat <= TIMEOUT);
            dur       = t.err ? TIMEOUT : lat;
            t.rdata   = t.err ? '0 : ack_data;
            t.end_cyc = cyc + dur;
            sb.push_back(t);
            free_at    = cyc + dur + 1;
            last_owner = owner;
            ack_at     = (lat == 0) ? -1 : cyc + lat;
          end
        end else if (!desync) begin
          check("no_spurious_start", started, 0);
        end
      end
      bus.mem_ack   = (ack_at >= 0) && (cyc + 1 == ack_at);
      bus.mem_rdata = bus.mem_ack ? ack_data : DW'($urandom);
      prev_req      = bus.mem_req;
    end
  end

  initial begin : monitor
    txn_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && cyc == sb[0].end_cyc) begin
        e = sb.pop_front();
        check("done_owner", {bus.done1, bus.done0}, (e.owner == 1) ? 2'b10 : 2'b01);
        check("done_err",   bus.err,   e.err);
        check("done_rdata", bus.rdata, e.rdata);
        check("release",    {bus.mem_req, bus.gnt1, bus.gnt0}, 3'b000);
      end else begin
        check("no_stray_done", {bus.done1, bus.done0, bus.err}, 3'b000);
        if (sb.size() > 0) begin
          e = sb[0];
          check("busy_hold", {bus.mem_req, bus.sel, bus.gnt1, bus.gnt0, bus.mem_we},
                {1'b1, e.owner == 1, e.owner == 1, e.owner == 0, e.we});
          check("busy_addr",  bus.mem_addr,  e.addr);
          check("busy_wdata", bus.mem_wdata, e.wdata);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    set_inputs(0, 1'b0, '0, '0, 1'b0);
    set_inputs(1, 1'b0, '0, '0, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("por");

    // Single read, ack three cycles into the transaction.
    force_lat.push_back(3);
    force_data.push_back(32'hDEAD_BEEF);
    issue(0, 32'h100, 32'h0, 1'b0, 1'b0);

    // Tie straight after reset: requester 0 first, then strict alternation.
    do_reset(2);
    repeat (4) force_lat.push_back(1);
    fork
      begin
        issue(0, 32'h10, 32'h1, 1'b0, 1'b0);
        issue(0, 32'h14, 32'h2, 1'b0, 1'b0);
      end
      begin
        issue(1, 32'h20, 32'h3, 1'b1, 1'b0);
        issue(1, 32'h24, 32'h4, 1'b0, 1'b0);
      end
    join

    // Write from requester 1.
    force_lat.push_back(2);
    issue(1, 32'h2000, 32'h1234_5678, 1'b1, 1'b0);

    // Watchdog abort of requester 0, then a tie must go to requester 1.
    force_lat.push_back(0);
    issue(0, 32'h500, 32'h55, 1'b0, 1'b0);
    force_lat.push_back(2);
    force_lat.push_back(2);
    fork
      issue(0, 32'h600, 32'h66, 1'b1, 1'b0);
      issue(1, 32'h700, 32'h77, 1'b0, 1'b0);
    join

    // Ack on the very last watchdog cycle completes without error.
    force_lat.push_back(TIMEOUT);
    force_data.push_back(32'hCAFE_F00D);
    issue(0, 32'h800, 32'h0, 1'b0, 1'b0);

    // Reset two cycles into a transaction: no done, requester 1 granted right after.
    force_lat.push_back(0);
    force_lat.push_back(2);
    @(negedge clk);
    set_inputs(0, 1'b1, 32'h300, 32'h33, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.gnt0 && n < 50);
    check("rst_busy_gnt0", bus.gnt0, 1);
    @(negedge clk);
    reset = 1'b1;
    set_inputs(0, 1'b0, '0, '0, 1'b0);
    set_inputs(1, 1'b1, 32'h440, 32'h44, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("busy_reset");
    wait_done(1, 1'b0);

    // Randomized traffic from both requesters with random memory latency.
    fork
      begin
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          issue(0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
        end
      end
      begin
        for (int j = 0; j < 25; j++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          issue(1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
        end
      end
    join

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
